// File: rtl/classify_pipe_param_if.sv
// rtl/classify_pipe_param_if.sv - point-in / result-out handshake bundle for classify_pipe_param
interface classify_pipe_param_if #(
  parameter int DIM    = 7,
  parameter int CORD_W = 13,
  parameter int IDX_W  = 3,
  parameter int DIST_W = 30
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIM*CORD_W-1:0] in_point;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIM*CORD_W-1:0] out_point;
  logic [IDX_W-1:0]      out_idx;
  logic [DIST_W-1:0]     out_dist;

  modport master (
    output in_valid, in_point, out_ready,
    input  in_ready, out_valid, out_point, out_idx, out_dist
  );

  modport slave (
    input  in_valid, in_point, out_ready,
    output in_ready, out_valid, out_point, out_idx, out_dist
  );
endinterface

// File: rtl/classify_pipe_param.sv
// rtl/classify_pipe_param.sv - three-stage nearest-centroid classifier with valid/ready flow control
module classify_pipe_param #(
  parameter int NUM_CENT  = 8,
  parameter int DIM       = 7,
  parameter int CORD_W    = 13,
  parameter int DIST_MODE = 0,
  parameter int IDX_W     = $clog2(NUM_CENT),
  parameter int DIST_W    = 2*CORD_W + $clog2(DIM) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  classify_pipe_param_if.slave  strm,
  input  logic                  cent_wr_en,
  input  logic [IDX_W-1:0]      cent_wr_idx,
  input  logic [DIM*CORD_W-1:0] cent_wr_data,
  input  logic [NUM_CENT-1:0]   cent_active,
  input  logic [IDX_W-1:0]      cent_rd_idx,
  output logic [DIM*CORD_W-1:0] cent_rd_data,
  output logic                  pipe_empty
);

  localparam int PW     = DIM*CORD_W;
  localparam int LEAVES = 1 << $clog2(NUM_CENT);

  logic [PW-1:0]              cent [NUM_CENT];

  logic                       s1_valid;
  logic [PW-1:0]              s1_point;
  logic [NUM_CENT*DIST_W-1:0] s1_dist;

  logic                       s2_valid;
  logic [PW-1:0]              s2_point;
  logic [NUM_CENT*DIST_W-1:0] s2_dist;
  logic [IDX_W+DIST_W-1:0]    s2_best;

  logic                       s3_valid;
  logic [PW-1:0]              s3_point;
  logic [IDX_W-1:0]           s3_idx;
  logic [DIST_W-1:0]          s3_dist;

  logic                       s1_load;
  logic                       s2_load;
  logic                       s3_load;
  logic                       s3_adv;

  function automatic logic [DIST_W-1:0] dist_f(input logic [PW-1:0] p, input logic [PW-1:0] c);
    logic [DIST_W-1:0]   acc;
    logic [CORD_W-1:0]   a;
    logic [CORD_W-1:0]   b;
    logic [CORD_W-1:0]   d;
    logic [2*CORD_W-1:0] sq;
    acc = '0;
    for (int k = 0; k < DIM; k++) begin
      a = p[k*CORD_W +: CORD_W];
      b = c[k*CORD_W +: CORD_W];
      d = (a >= b) ? (a - b) : (b - a);
      if (DIST_MODE == 1) begin
        sq  = {{CORD_W{1'b0}}, d} * {{CORD_W{1'b0}}, d};
        acc = acc + DIST_W'(sq);
      end else begin
        acc = acc + DIST_W'(d);
      end
    end
    return acc;
  endfunction

  // Balanced reduction keeps the compare depth at log2(NUM_CENT); the left
  // (lower-index) operand wins ties so the lowest active index is chosen.
  function automatic logic [IDX_W+DIST_W-1:0] argmin_f(
    input logic [NUM_CENT*DIST_W-1:0] d,
    input logic [NUM_CENT-1:0]        act
  );
    logic              v  [2*LEAVES];
    logic [DIST_W-1:0] dd [2*LEAVES];
    logic [IDX_W-1:0]  ix [2*LEAVES];
    for (int i = 0; i < 2*LEAVES; i++) begin
      v[i]  = 1'b0;
      dd[i] = '0;
      ix[i] = '0;
    end
    for (int i = 0; i < NUM_CENT; i++) begin
      v[LEAVES+i]  = act[i];
      dd[LEAVES+i] = d[i*DIST_W +: DIST_W];
      ix[LEAVES+i] = IDX_W'(i);
    end
    for (int n = LEAVES-1; n >= 1; n--) begin
      if (v[2*n] && (!v[2*n+1] || (dd[2*n] <= dd[2*n+1]))) begin
        v[n]  = 1'b1;
        dd[n] = dd[2*n];
        ix[n] = ix[2*n];
      end else if (v[2*n+1]) begin
        v[n]  = 1'b1;
        dd[n] = dd[2*n+1];
        ix[n] = ix[2*n+1];
      end
    end
    if (v[1]) begin
      return {ix[1], dd[1]};
    end
    return {{IDX_W{1'b0}}, {DIST_W{1'b1}}};
  endfunction

  assign s3_adv        = s3_valid & strm.out_ready;
  assign s3_load       = s2_valid & (~s3_valid | s3_adv);
  assign s2_load       = s1_valid & (~s2_valid | s3_load);
  assign strm.in_ready = ~cent_wr_en & ~flush & (~s1_valid | s2_load);
  assign s1_load       = strm.in_valid & strm.in_ready;

  assign strm.out_valid = s3_valid;
  assign strm.out_point = s3_point;
  assign strm.out_idx   = s3_idx;
  assign strm.out_dist  = s3_dist;
  assign pipe_empty     = ~(s1_valid | s2_valid | s3_valid);

  // Out-of-range indices match no entry, so writes drop and reads return 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CENT; i++) begin
        cent[i] <= '0;
      end
    end else if (cent_wr_en) begin
      for (int i = 0; i < NUM_CENT; i++) begin
        if (cent_wr_idx == IDX_W'(i)) begin
          cent[i] <= cent_wr_data;
        end
      end
    end
  end

  always_comb begin
    cent_rd_data = '0;
    for (int i = 0; i < NUM_CENT; i++) begin
      if (cent_rd_idx == IDX_W'(i)) begin
        cent_rd_data = cent[i];
      end
    end
  end

  always_comb begin
    s1_dist = '0;
    for (int i = 0; i < NUM_CENT; i++) begin
      s1_dist[i*DIST_W +: DIST_W] = dist_f(s1_point, cent[i]);
    end
  end

  assign s2_best = argmin_f(s2_dist, cent_active);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_point <= '0;
      s2_valid <= 1'b0;
      s2_point <= '0;
      s2_dist  <= '0;
      s3_valid <= 1'b0;
      s3_point <= '0;
      s3_idx   <= '0;
      s3_dist  <= '0;
    end else begin
      if (s1_load) begin
        s1_point <= strm.in_point;
      end
      if (s2_load) begin
        s2_point <= s1_point;
        s2_dist  <= s1_dist;
      end
      if (s3_load) begin
        s3_point          <= s2_point;
        {s3_idx, s3_dist} <= s2_best;
      end
      if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
        s3_valid <= 1'b0;
      end else begin
        s1_valid <= s1_load | (s1_valid & ~s2_load);
        s2_valid <= s2_load | (s2_valid & ~s3_load);
        s3_valid <= s3_load | (s3_valid & ~s3_adv);
      end
    end
  end

endmodule

// File: tb/tb_classify_pipe_param.sv
// tb/tb_classify_pipe_param.sv - directed self-checking bench for classify_pipe_param
module tb_classify_pipe_param;
  localparam int NC  = 8;
  localparam int DIM = 7;
  localparam int CW  = 13;
  localparam int IW  = 4;
  localparam int DW  = 2*CW + $clog2(DIM) + 1;
  localparam int PW  = DIM*CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          cent_wr_en = 1'b0;
  logic [IW-1:0] cent_wr_idx = '0;
  logic [PW-1:0] cent_wr_data = '0;
  logic [NC-1:0] cent_active = '0;
  logic [IW-1:0] cent_rd_idx = '0;
  logic [PW-1:0] rd1;
  logic [PW-1:0] rd2;
  logic          empty1;
  logic          empty2;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] all_ones = '1;

  classify_pipe_param_if #(.DIM(DIM), .CORD_W(CW), .IDX_W(IW), .DIST_W(DW)) b1 ();
  classify_pipe_param_if #(.DIM(DIM), .CORD_W(CW), .IDX_W(IW), .DIST_W(DW)) b2 ();

  classify_pipe_param #(.NUM_CENT(NC), .DIM(DIM), .CORD_W(CW), .DIST_MODE(0), .IDX_W(IW), .DIST_W(DW)) dut_l1 (
    .clk(clk), .rst(rst), .flush(flush), .strm(b1),
    .cent_wr_en(cent_wr_en), .cent_wr_idx(cent_wr_idx), .cent_wr_data(cent_wr_data),
    .cent_active(cent_active), .cent_rd_idx(cent_rd_idx), .cent_rd_data(rd1), .pipe_empty(empty1)
  );

  classify_pipe_param #(.NUM_CENT(NC), .DIM(DIM), .CORD_W(CW), .DIST_MODE(1), .IDX_W(IW), .DIST_W(DW)) dut_l2 (
    .clk(clk), .rst(rst), .flush(flush), .strm(b2),
    .cent_wr_en(cent_wr_en), .cent_wr_idx(cent_wr_idx), .cent_wr_data(cent_wr_data),
    .cent_active(cent_active), .cent_rd_idx(cent_rd_idx), .cent_rd_data(rd2), .pipe_empty(empty2)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] rep(input int v);
    return {DIM{CW'(v)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_cent(input int idx, input int v);
    cent_wr_en   = 1'b1;
    cent_wr_idx  = IW'(idx);
    cent_wr_data = rep(v);
    tick();
    cent_wr_en   = 1'b0;
  endtask

  // Leaves the result of one point sitting on the selected output.
  task automatic run_point(input bit sel, input int v);
    if (sel) begin
      b2.in_valid = 1'b1;
      b2.in_point = rep(v);
    end else begin
      b1.in_valid = 1'b1;
      b1.in_point = rep(v);
    end
    tick();
    b1.in_valid = 1'b0;
    b2.in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", b1.out_valid); end
    checks++; if (b1.out_point !== '0) begin errors++; $display("FAIL rst_out_point got %0h want 0", b1.out_point); end
    checks++; if (b1.out_idx !== '0) begin errors++; $display("FAIL rst_out_idx got %0d want 0", b1.out_idx); end
    checks++; if (b1.out_dist !== '0) begin errors++; $display("FAIL rst_out_dist got %0d want 0", b1.out_dist); end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL rst_pipe_empty got %0b want 1", empty1); end
    checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", b1.in_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_l1();
    wr_cent(1, 100);
    cent_active = 8'b0000_0011;
    cent_rd_idx = 4'd1;
    #1;
    checks++; if (rd1 !== rep(100)) begin errors++; $display("FAIL l1_readback got %0h want %0h", rd1, rep(100)); end
    b1.in_valid = 1'b1;
    b1.in_point = rep(60);
    #1;
    checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL l1_in_ready got %0b want 1", b1.in_ready); end
    tick();
    b1.in_valid = 1'b0;
    tick();
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL l1_early_valid got %0b want 0", b1.out_valid); end
    tick();
    checks++; if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL l1_valid got %0b want 1", b1.out_valid); end
    checks++; if (b1.out_idx !== 4'd1) begin errors++; $display("FAIL l1_idx got %0d want 1", b1.out_idx); end
    checks++; if (b1.out_dist !== DW'(280)) begin errors++; $display("FAIL l1_dist got %0d want 280", b1.out_dist); end
    checks++; if (b1.out_point !== rep(60)) begin errors++; $display("FAIL l1_point got %0h want %0h", b1.out_point, rep(60)); end
  endtask

  task automatic test_tie_mask();
    run_point(1'b0, 50);
    checks++; if (b1.out_idx !== 4'd0) begin errors++; $display("FAIL tie_idx got %0d want 0", b1.out_idx); end
    checks++; if (b1.out_dist !== DW'(350)) begin errors++; $display("FAIL tie_dist got %0d want 350", b1.out_dist); end
    cent_active = 8'b0000_0010;
    run_point(1'b0, 50);
    checks++; if (b1.out_idx !== 4'd1) begin errors++; $display("FAIL mask_idx got %0d want 1", b1.out_idx); end
    checks++; if (b1.out_dist !== DW'(350)) begin errors++; $display("FAIL mask_dist got %0d want 350", b1.out_dist); end
    cent_active = 8'b0000_0000;
    run_point(1'b0, 50);
    checks++; if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL none_valid got %0b want 1", b1.out_valid); end
    checks++; if (b1.out_idx !== 4'd0) begin errors++; $display("FAIL none_idx got %0d want 0", b1.out_idx); end
    checks++; if (b1.out_dist !== all_ones) begin errors++; $display("FAIL none_dist got %0h want %0h", b1.out_dist, all_ones); end
  endtask

  task automatic test_l2();
    wr_cent(0, 10);
    wr_cent(1, 20);
    cent_active = 8'b0000_0011;
    cent_rd_idx = 4'd1;
    #1;
    checks++; if (rd2 !== rep(20)) begin errors++; $display("FAIL l2_readback got %0h want %0h", rd2, rep(20)); end
    run_point(1'b1, 13);
    checks++; if (b2.out_valid !== 1'b1) begin errors++; $display("FAIL l2_valid got %0b want 1", b2.out_valid); end
    checks++; if (b2.out_idx !== 4'd0) begin errors++; $display("FAIL l2_idx got %0d want 0", b2.out_idx); end
    checks++; if (b2.out_dist !== DW'(63)) begin errors++; $display("FAIL l2_dist got %0d want 63", b2.out_dist); end
  endtask

  task automatic test_backpressure();
    int  vals [6] = '{3, 12, 16, 25, 14, 1};
    int  sent = 0;
    int  rcv = 0;
    int  gap = 0;
    logic acc;
    b1.out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      b1.in_valid = (sent < 6);
      b1.in_point = rep(vals[(sent < 6) ? sent : 0]);
      #1;
      acc = b1.in_valid & b1.in_ready;
      tick();
      if (acc) sent++;
    end
    checks++; if (sent !== 3) begin errors++; $display("FAIL bp_accepted got %0d want 3", sent); end
    checks++; if (b1.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0b want 0", b1.in_ready); end
    checks++; if (b1.out_point !== rep(3)) begin errors++; $display("FAIL bp_hold_point got %0h want %0h", b1.out_point, rep(3)); end
    checks++; if (b1.out_dist !== DW'(49)) begin errors++; $display("FAIL bp_hold_dist got %0d want 49", b1.out_dist); end
    b1.out_ready = 1'b1;
    for (int c = 0; c < 12 && rcv < 6; c++) begin
      b1.in_valid = (sent < 6);
      b1.in_point = rep(vals[(sent < 6) ? sent : 0]);
      #1;
      acc = b1.in_valid & b1.in_ready;
      if (b1.out_valid) begin
        checks++; if (b1.out_point !== rep(vals[rcv])) begin errors++; $display("FAIL bp_order%0d got %0h want %0h", rcv, b1.out_point, rep(vals[rcv])); end
        rcv++;
      end else begin
        gap++;
      end
      tick();
      if (acc) sent++;
    end
    b1.in_valid = 1'b0;
    checks++; if (rcv !== 6) begin errors++; $display("FAIL bp_received got %0d want 6", rcv); end
    checks++; if (gap !== 0) begin errors++; $display("FAIL bp_gaps got %0d want 0", gap); end
  endtask

  task automatic test_collision();
    b1.out_ready = 1'b1;
    b1.in_valid  = 1'b1;
    b1.in_point  = rep(14);
    #1;
    tick();
    cent_wr_en   = 1'b1;
    cent_wr_idx  = 4'd1;
    cent_wr_data = rep(14);
    b1.in_point  = rep(2);
    #1;
    checks++; if (b1.in_ready !== 1'b0) begin errors++; $display("FAIL col_in_ready got %0b want 0", b1.in_ready); end
    tick();
    cent_wr_en  = 1'b0;
    b1.in_valid = 1'b0;
    tick();
    checks++; if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL col_valid got %0b want 1", b1.out_valid); end
    checks++; if (b1.out_idx !== 4'd0) begin errors++; $display("FAIL col_idx got %0d want 0", b1.out_idx); end
    checks++; if (b1.out_dist !== DW'(28)) begin errors++; $display("FAIL col_dist got %0d want 28", b1.out_dist); end
    tick();
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL col_dropped got %0b want 0", b1.out_valid); end
    cent_rd_idx = 4'd1;
    #1;
    checks++; if (rd1 !== rep(14)) begin errors++; $display("FAIL col_written got %0h want %0h", rd1, rep(14)); end
    wr_cent(15, 999);
    cent_rd_idx = 4'd7;
    #1;
    checks++; if (rd1 !== '0) begin errors++; $display("FAIL oob_c7 got %0h want 0", rd1); end
    cent_rd_idx = 4'd0;
    #1;
    checks++; if (rd1 !== rep(10)) begin errors++; $display("FAIL oob_c0 got %0h want %0h", rd1, rep(10)); end
    cent_rd_idx = 4'd15;
    #1;
    checks++; if (rd1 !== '0) begin errors++; $display("FAIL oob_read got %0h want 0", rd1); end
  endtask

  task automatic test_flush();
    b1.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      b1.in_valid = 1'b1;
      b1.in_point = rep(5 + c);
      tick();
    end
    checks++; if (empty1 !== 1'b0) begin errors++; $display("FAIL fl_full got %0b want 0", empty1); end
    b1.out_ready = 1'b1;
    flush = 1'b1;
    #1;
    checks++; if (b1.in_ready !== 1'b0) begin errors++; $display("FAIL fl_in_ready got %0b want 0", b1.in_ready); end
    tick();
    flush = 1'b0;
    b1.in_valid = 1'b0;
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL fl_empty got %0b want 1", empty1); end
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL fl_out_valid got %0b want 0", b1.out_valid); end
    cent_rd_idx = 4'd0;
    #1;
    checks++; if (rd1 !== rep(10)) begin errors++; $display("FAIL fl_cent got %0h want %0h", rd1, rep(10)); end
  endtask

  task automatic test_reset_mid();
    b1.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      b1.in_valid = 1'b1;
      b1.in_point = rep(30 + c);
      tick();
    end
    b1.in_valid = 1'b0;
    checks++; if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid got %0b want 1", b1.out_valid); end
    #2;
    rst = 1'b1;
    cent_rd_idx = 4'd1;
    #1;
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got %0b want 0", b1.out_valid); end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL rm_empty got %0b want 1", empty1); end
    checks++; if (rd1 !== '0) begin errors++; $display("FAIL rm_cent got %0h want 0", rd1); end
    tick();
    rst = 1'b0;
    b1.out_ready = 1'b1;
    tick();
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL rm_after got %0b want 0", b1.out_valid); end
  endtask

  initial begin
    b1.in_valid  = 1'b0;
    b1.in_point  = '0;
    b1.out_ready = 1'b1;
    b2.in_valid  = 1'b0;
    b2.in_point  = '0;
    b2.out_ready = 1'b1;
    test_reset();
    test_l1();
    test_tie_mask();
    test_l2();
    test_backpressure();
    test_collision();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
